// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, next-PC select, IF/ID register and IDLE/RUN/HALT control
module instr_fetch_unit #(
  parameter int NB_PC = 32,
  parameter int NB_INSTR = 32,
  parameter logic [NB_PC-1:0] RESET_PC = '0,
  parameter logic [NB_INSTR-1:0] NOP_INSTR = 32'h00000013,
  parameter logic [NB_INSTR-1:0] HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_en,
  input  logic                i_stall,
  input  logic [1:0]          i_pcSrc,
  input  logic                i_flush,
  input  logic [NB_PC-1:0]    i_branch_target,
  input  logic [NB_PC-1:0]    i_jalr_target,
  input  logic [NB_INSTR-1:0] i_instr,
  output logic [NB_PC-1:0]    o_imem_addr,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_PC-1:0]    o_pc_plus4,
  output logic [NB_INSTR-1:0] o_instr,
  output logic                o_valid,
  output logic                o_halted,
  output logic [31:0]         o_fetch_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t r_state, w_state_next;
  logic [NB_PC-1:0] r_pc, w_pc4, w_target;
  logic w_adv, w_halt, w_fetch;
  assign w_adv = (r_state == RUN) && i_en;
  assign w_pc4 = r_pc + NB_PC'(4);
  assign w_halt = w_adv && !i_flush && !i_stall && (i_instr == HALT_INSTR);
  assign w_fetch = w_adv && !i_flush && !i_stall && (i_instr != HALT_INSTR);
  assign o_imem_addr = r_pc;
  assign o_halted = (r_state == HALT);
  // redirect target used when a flush is taken; jalr targets are forced even
  always_comb w_target = i_pcSrc == 2'b01 ? i_branch_target :
                         i_pcSrc == 2'b10 ? {i_jalr_target[NB_PC-1:1], 1'b0} : w_pc4;
  // state register
  always_ff @(posedge clk) r_state <= i_rst ? IDLE : w_state_next;
  // next state: start leaves IDLE, a halt marker fetched in RUN parks in HALT
  always_comb begin
    w_state_next = r_state;
    w_state_next = (r_state == IDLE && i_start) ? RUN : w_state_next;
    w_state_next = w_halt ? HALT : w_state_next;
  end
  // PC, IF/ID register and fetch counter; flush wins over stall and halt
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
      o_pc <= '0;
      o_pc_plus4 <= '0;
      o_instr <= NOP_INSTR;
      o_valid <= 1'b0;
      o_fetch_count <= '0;
    end else if (w_adv && i_flush) begin
      r_pc <= w_target;
      o_instr <= NOP_INSTR;
      o_valid <= 1'b0;
    end else if (w_halt) begin
      o_instr <= NOP_INSTR;
      o_valid <= 1'b0;
    end else if (w_fetch) begin
      r_pc <= w_pc4;
      o_pc <= r_pc;
      o_pc_plus4 <= w_pc4;
      o_instr <= i_instr;
      o_valid <= 1'b1;
      o_fetch_count <= o_fetch_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table vectors, hand sequences and random run against a reference model
module tb_instr_fetch_unit;
  logic clk = 0, i_rst = 0, i_start = 0, i_en = 0, i_stall = 0, i_flush = 0;
  logic [1:0] i_pcSrc = 0;
  logic [31:0] i_branch_target = 0, i_jalr_target = 0, i_instr;
  logic [31:0] o_imem_addr, o_pc, o_pc_plus4, o_instr, o_fetch_count;
  logic o_valid, o_halted;
  logic halt_en = 0;
  logic [31:0] halt_addr = 32'h30;
  int n_chk = 0, n_pass = 0;

  instr_fetch_unit dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_en(i_en), .i_stall(i_stall),
    .i_pcSrc(i_pcSrc), .i_flush(i_flush), .i_branch_target(i_branch_target),
    .i_jalr_target(i_jalr_target), .i_instr(i_instr), .o_imem_addr(o_imem_addr),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_instr(o_instr), .o_valid(o_valid),
    .o_halted(o_halted), .o_fetch_count(o_fetch_count)
  );

  always #5 clk = ~clk;
  assign i_instr = (halt_en && o_imem_addr == halt_addr) ? 32'hFFFFFFFF : o_imem_addr ^ 32'h5A5A0003;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (halt_en && a == halt_addr) ? 32'hFFFFFFFF : a ^ 32'h5A5A0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference model: 0 idle, 1 running, 2 halted
  int m_mode;
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic m_valid;

  task automatic model(input bit rst, start, en, stall, flush, input logic [1:0] src,
                       input logic [31:0] bt, jt);
    logic [31:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_ipc = 0; m_instr = 32'h13; m_valid = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1 && en) begin
      w = imem(m_pc);
      if (flush) begin
        case (src)
          2'b01: m_pc = bt;
          2'b10: m_pc = jt & 32'hFFFFFFFE;
          default: m_pc = m_pc + 4;
        endcase
        m_instr = 32'h13; m_valid = 0;
      end else if (stall) begin
      end else if (w == 32'hFFFFFFFF) begin
        m_instr = 32'h13; m_valid = 0; m_mode = 2;
      end else begin
        m_ipc = m_pc; m_instr = w; m_valid = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic cyc(input bit rst, start, en, stall, flush, input logic [1:0] src,
                     input logic [31:0] bt, jt);
    i_rst = rst; i_start = start; i_en = en; i_stall = stall; i_flush = flush;
    i_pcSrc = src; i_branch_target = bt; i_jalr_target = jt;
    model(rst, start, en, stall, flush, src, bt, jt);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst, start, en, stall, flush;
    bit [1:0] src;
    bit [31:0] bt, jt, addr, instr, pc, cnt;
    bit valid, halted;
  } vec_t;
  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,0,0,           32'h0,  32'h13,       32'h0,  0, 0, 0};
    tbl[1]  = '{0,1,0,0,0,0,0,0,           32'h0,  32'h13,       32'h0,  0, 0, 0};
    tbl[2]  = '{0,0,1,0,0,0,0,0,           32'h4,  32'h5A5A0003, 32'h0,  1, 1, 0};
    tbl[3]  = '{0,0,1,0,0,0,0,0,           32'h8,  32'h5A5A0007, 32'h4,  2, 1, 0};
    tbl[4]  = '{0,0,1,0,0,0,0,0,           32'hC,  32'h5A5A000B, 32'h8,  3, 1, 0};
    tbl[5]  = '{0,0,1,0,0,0,0,0,           32'h10, 32'h5A5A000F, 32'hC,  4, 1, 0};
    tbl[6]  = '{0,0,1,1,0,0,0,0,           32'h10, 32'h5A5A000F, 32'hC,  4, 1, 0};
    tbl[7]  = '{0,0,1,1,0,0,0,0,           32'h10, 32'h5A5A000F, 32'hC,  4, 1, 0};
    tbl[8]  = '{0,0,1,0,0,0,0,0,           32'h14, 32'h5A5A0013, 32'h10, 5, 1, 0};
    tbl[9]  = '{0,0,1,0,0,0,0,0,           32'h18, 32'h5A5A0017, 32'h14, 6, 1, 0};
    tbl[10] = '{0,0,1,0,0,0,0,0,           32'h1C, 32'h5A5A001B, 32'h18, 7, 1, 0};
    tbl[11] = '{0,0,1,0,0,0,0,0,           32'h20, 32'h5A5A001F, 32'h1C, 8, 1, 0};
    tbl[12] = '{0,0,1,1,1,1,32'h100,0,     32'h100,32'h13,       32'h0,  8, 0, 0};
    tbl[13] = '{0,0,1,0,1,2,0,32'h205,     32'h204,32'h13,       32'h0,  8, 0, 0};
    tbl[14] = '{0,0,1,0,0,0,0,0,           32'h208,32'h5A5A0207, 32'h204,9, 1, 0};
    tbl[15] = '{0,0,0,0,0,0,0,0,           32'h208,32'h5A5A0207, 32'h204,9, 1, 0};
    tbl[16] = '{0,0,0,0,0,0,0,0,           32'h208,32'h5A5A0207, 32'h204,9, 1, 0};
    tbl[17] = '{0,0,0,0,0,0,0,0,           32'h208,32'h5A5A0207, 32'h204,9, 1, 0};
    #1;
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].rst, tbl[i].start, tbl[i].en, tbl[i].stall, tbl[i].flush, tbl[i].src,
          tbl[i].bt, tbl[i].jt);
      chk($sformatf("tbl%0d addr", i), o_imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d instr", i), o_instr, tbl[i].instr);
      chk($sformatf("tbl%0d valid", i), {31'b0, o_valid}, {31'b0, tbl[i].valid});
      chk($sformatf("tbl%0d halted", i), {31'b0, o_halted}, {31'b0, tbl[i].halted});
      chk($sformatf("tbl%0d count", i), o_fetch_count, tbl[i].cnt);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d pc", i), o_pc, tbl[i].pc);
        chk($sformatf("tbl%0d pc4", i), o_pc_plus4, tbl[i].pc + 4);
      end
    end
    // halt marker at 0x30
    halt_en = 1;
    cyc(1,0,0,0,0,0,0,0);
    cyc(0,1,0,0,0,0,0,0);
    repeat (12) cyc(0,0,1,0,0,0,0,0);
    chk("pre-halt addr", o_imem_addr, 32'h30);
    chk("pre-halt count", o_fetch_count, 12);
    cyc(0,0,1,0,0,0,0,0);
    chk("halt halted", {31'b0, o_halted}, 1);
    chk("halt addr", o_imem_addr, 32'h30);
    chk("halt valid", {31'b0, o_valid}, 0);
    chk("halt instr", o_instr, 32'h13);
    chk("halt count", o_fetch_count, 12);
    repeat (2) cyc(0,1,1,0,0,0,0,0);
    chk("halt hold halted", {31'b0, o_halted}, 1);
    chk("halt hold addr", o_imem_addr, 32'h30);
    chk("halt hold count", o_fetch_count, 12);
    cyc(1,0,1,0,0,0,0,0);
    chk("rst halted", {31'b0, o_halted}, 0);
    chk("rst addr", o_imem_addr, 32'h0);
    chk("rst count", o_fetch_count, 0);
    cyc(0,0,1,0,0,0,0,0);
    chk("idle no advance", o_imem_addr, 32'h0);
    // PC wrap past the top of the address space
    cyc(0,1,0,0,0,0,0,0);
    cyc(0,0,1,0,1,1,32'hFFFFFFFC,0);
    chk("wrap redirect", o_imem_addr, 32'hFFFFFFFC);
    cyc(0,0,1,0,0,0,0,0);
    chk("wrap addr", o_imem_addr, 32'h0);
    chk("wrap instr", o_instr, 32'hA5A5FFFF);
    chk("wrap pc", o_pc, 32'hFFFFFFFC);
    chk("wrap pc4", o_pc_plus4, 32'h0);
    chk("wrap count", o_fetch_count, 1);
    // random stimulus against the model
    halt_addr = 32'h40;
    cyc(1,0,0,0,0,0,0,0);
    for (int i = 0; i < 600; i++) begin
      bit rst, start, en, stall, flush;
      logic [1:0] src;
      rst = ($urandom % 50) == 0;
      start = ($urandom % 4) == 0;
      en = ($urandom % 4) != 0;
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 6) == 0;
      src = flush ? 2'($urandom) : 2'b00;
      cyc(rst, start, en, stall, flush, src, $urandom_range(0, 31) * 4, $urandom_range(0, 255));
      chk("rnd addr", o_imem_addr, m_pc);
      chk("rnd instr", o_instr, m_instr);
      chk("rnd valid", {31'b0, o_valid}, {31'b0, m_valid});
      chk("rnd halted", {31'b0, o_halted}, {31'b0, m_mode == 2});
      chk("rnd count", o_fetch_count, m_cnt);
      if (m_valid) begin
        chk("rnd pc", o_pc, m_ipc);
        chk("rnd pc4", o_pc_plus4, m_ipc + 4);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter NB_PC, default 32, meaning program counter width.
REQ-002 The module SHALL have parameter NB_INSTR, default 32, meaning instruction width.
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning PC value after reset.
REQ-004 The module SHALL have parameter NOP_INSTR, default 32'h00000013, meaning bubble instruction (addi x0,x0,0).
REQ-005 The module SHALL have parameter HALT_INSTR, default 32'hFFFFFFFF, meaning the halt marker instruction.
REQ-006 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port i_rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 The module SHALL have port i_start, input, 1 bit, leaves IDLE.
REQ-009 The module SHALL have port i_en, input, 1 bit, global advance enable (debug stepping).
REQ-010 The module SHALL have port i_stall, input, 1 bit, load-use hazard stall request.
REQ-011 The module SHALL have port i_pcSrc, input, 2 bits, next-PC select from the branch control unit.
REQ-012 The module SHALL have port i_flush, input, 1 bit, flush request from the branch control unit.
REQ-013 The module SHALL have port i_branch_target, input, NB_PC bits, PC+imm target.
REQ-014 The module SHALL have port i_jalr_target, input, NB_PC bits, rs1+imm target.
REQ-015 The module SHALL have port i_instr, input, NB_INSTR bits, combinational instruction-memory read data for o_imem_addr.
REQ-016 The module SHALL have port o_imem_addr, output, NB_PC bits, equal to the current PC register.
REQ-017 The module SHALL have ports o_pc, o_pc_plus4 (output, NB_PC bits) and o_instr (output, NB_INSTR bits), the IF/ID register contents.
REQ-018 The module SHALL have port o_valid, output, 1 bit, meaning the IF/ID register holds a real instruction.
REQ-019 The module SHALL have port o_halted, output, 1 bit, meaning FSM is in HALT.
REQ-020 The module SHALL have port o_fetch_count, output, 32 bits, count of valid instructions captured.

Function
REQ-021 The FSM SHALL have states IDLE, RUN and HALT: IDLE->RUN on i_start; RUN->HALT per REQ-027; HALT leaves only via reset; i_start is ignored outside IDLE.
REQ-022 An advance SHALL occur only when state==RUN and i_en=1; otherwise the PC, IF/ID register and counter hold.
REQ-023 Next PC SHALL be selected as: pcSrc 00 -> PC+4; 01 -> i_branch_target; 10 -> i_jalr_target with bit0 cleared; 11 -> PC+4; PC+4 wraps modulo 2^NB_PC.
REQ-024 On an advance with i_flush=1, the module SHALL load the selected next PC and load IF/ID with o_instr=NOP_INSTR and o_valid=0; flush has priority over stall and halt.
REQ-025 On an advance with i_flush=0 and i_stall=1, the PC and IF/ID register SHALL hold.
REQ-026 On an advance with i_flush=0, i_stall=0 and i_instr!=HALT_INSTR, the module SHALL set PC<=PC+4 and capture o_pc<=PC, o_pc_plus4<=PC+4, o_instr<=i_instr, o_valid<=1; o_fetch_count SHALL increment, wrapping at 2^32.
REQ-027 On an advance with i_flush=0, i_stall=0 and i_instr==HALT_INSTR, the PC SHALL hold, IF/ID SHALL be loaded with NOP and o_valid=0, the counter SHALL hold, and the FSM SHALL go to HALT.
REQ-028 IF/ID capture SHALL take one cycle: an instruction at o_imem_addr in cycle N SHALL appear on o_instr after edge N+1.

Reset
REQ-029 While i_rst=1 at a rising edge: PC<=RESET_PC, o_pc<=0, o_pc_plus4<=0, o_instr<=NOP_INSTR, o_valid<=0, o_fetch_count<=0, FSM<=IDLE, o_halted=0; reset overrides all other inputs, including mid-run and in HALT.

Verification
REQ-030 Reset, i_start, i_en=1, i_pcSrc=00, imem returns distinct words -> o_imem_addr 0,4,8,...; o_pc lags by one cycle; o_fetch_count increments per cycle.
REQ-031 At PC=0x10, i_stall=1 for 2 cycles -> PC and IF/ID held 2 cycles, then o_imem_addr=0x14.
REQ-032 At PC=0x20, i_flush=1, i_pcSrc=01, i_branch_target=0x100, with i_stall=1 in the same cycle -> next o_imem_addr=0x100, o_instr=0x00000013, o_valid=0.
REQ-033 i_flush=1, i_pcSrc=10, i_jalr_target=0x205 -> o_imem_addr=0x204.
REQ-034 imem returns 0xFFFFFFFF at 0x30 -> o_halted=1, PC stuck at 0x30, count frozen; i_start ignored; i_rst -> PC=0, IDLE.
REQ-035 PC=0xFFFFFFFC with pcSrc=00 -> next PC=0x00000000; i_en=0 for 3 cycles -> no state change.
